// File: rtl/clock_div_checker.sv
// clock_div_checker: monitors the /2, /4, /8 and /16 outputs of a binary
// clock divider, all sampled in the clk_in domain.
//
// Every toggle interval is measured against the expected half-period
// (1, 2, 4 and 8 cycles). A sticky per-channel error bit is set on a bad
// interval, or as soon as a toggle is overdue. The monitor reports lock once
// every channel has seen LOCK_TOGGLES consecutive correct intervals.
//
// Optional feature: define CLK_DIV_CHK_PHASE_EN to add a phase check. Each
// toggle of a /2N channel must coincide with a toggle of its /N neighbour.
// Without the macro, phase_err is tied low and no phase logic is built.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ACQ  00 | acquiring: waiting for every channel to collect LOCK_TOGGLES
// LOCK 01 | all channels locked, no error seen
// FAIL 10 | an error (or phase error) was seen; absorbing until rst
module clock_div_checker #(
  parameter int LOCK_TOGGLES = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       div_2,
  input  logic       div_4,
  input  logic       div_8,
  input  logic       div_16,
  output logic       locked,
  output logic       fail,
  output logic [3:0] err,
  output logic       phase_err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_ACQ  = 2'b00,
    ST_LOCK = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  localparam logic [3:0]  LOCK_CNT  = 4'(LOCK_TOGGLES);
  localparam logic [3:0]  SINCE_MAX = 4'd15;
  // Expected half-period per channel, packed channel 3 .. channel 0.
  localparam logic [15:0] HALF      = {4'd8, 4'd4, 4'd2, 4'd1};

  state_t          state_q, state_d;
  logic [3:0]      prev_q, prev_d;
  logic [3:0]      armed_q, armed_d;
  logic [3:0][3:0] since_q, since_d;
  logic [3:0][3:0] good_q, good_d;
  logic [3:0]      err_q, err_d;

  logic [3:0] div_s;
  logic [3:0] tog;
  logic [3:0] good_full;
  logic       phase_fail_d;

  assign div_s = {div_16, div_8, div_4, div_2};
  assign tog   = div_s ^ prev_q;

  // Per-channel interval measurement, lock qualification and sticky errors.
  always_comb begin
    prev_d    = div_s;
    armed_d   = armed_q;
    since_d   = since_q;
    good_d    = good_q;
    err_d     = err_q;
    good_full = '0;
    for (int k = 0; k < 4; k++) begin
      if (tog[k]) begin
        if (!armed_q[k]) begin
          armed_d[k] = 1'b1;
        end else if (({1'b0, since_q[k]} + 5'd1) == {1'b0, HALF[k*4 +: 4]}) begin
          if (good_q[k] < LOCK_CNT) begin
            good_d[k] = good_q[k] + 4'd1;
          end
        end else begin
          err_d[k]  = 1'b1;
          good_d[k] = '0;
        end
        since_d[k] = '0;
      end else begin
        if (since_q[k] != SINCE_MAX) begin
          since_d[k] = since_q[k] + 4'd1;
        end
        // Overdue toggle: flag now rather than waiting for the late edge.
        if (armed_q[k] && (since_q[k] >= HALF[k*4 +: 4])) begin
          err_d[k] = 1'b1;
        end
      end
      good_full[k] = (good_d[k] == LOCK_CNT);
    end
  end

`ifdef CLK_DIV_CHK_PHASE_EN
  logic phase_err_q, phase_err_d;
  logic phase_hit;

  // A /2N toggle without a simultaneous /N toggle means the divider lost phase.
  always_comb begin
    phase_hit = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (armed_q[k] && armed_q[k-1] && tog[k] && !tog[k-1]) begin
        phase_hit = 1'b1;
      end
    end
    phase_err_d  = phase_err_q | phase_hit;
    phase_fail_d = phase_err_d;
  end

  // Sticky phase error flag.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      phase_err_q <= 1'b0;
    end else begin
      phase_err_q <= phase_err_d;
    end
  end

  assign phase_err = phase_err_q;
`else
  assign phase_fail_d = 1'b0;
  assign phase_err    = 1'b0;
`endif

  // Next-state decode; uses next-cycle error/lock values so that status
  // changes land on the same edge that sampled the cause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACQ: begin
        if ((|err_d) || phase_fail_d) begin
          state_d = ST_FAIL;
        end else if (&good_full) begin
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if ((|err_d) || phase_fail_d) begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_ACQ;
    endcase
  end

  // State and per-channel registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_ACQ;
      prev_q  <= '0;
      armed_q <= '0;
      since_q <= '0;
      good_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      since_q <= since_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  assign locked = (state_q == ST_LOCK);
  assign fail   = (state_q == ST_FAIL);
  assign err    = err_q;
  assign state  = state_q;

endmodule

// File: tb/tb_clock_div_checker.sv
// Directed bench for clock_div_checker. The divider is modelled as a free
// counter; each channel can be offset, stuck or flipped for one sample.
module tb_clock_div_checker;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       div_2 = 1'b0, div_4 = 1'b0, div_8 = 1'b0, div_16 = 1'b0;
  logic       locked, fail, phase_err;
  logic [3:0] err;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  int         cnt;
  int         cnt_s;
  int         off [4];
  logic [3:0] stuck_en, stuck_val, flip;

  clock_div_checker dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_2     (div_2),
    .div_4     (div_4),
    .div_8     (div_8),
    .div_16    (div_16),
    .locked    (locked),
    .fail      (fail),
    .err       (err),
    .phase_err (phase_err),
    .state     (state)
  );

  always #5 clk_in = ~clk_in;

  task automatic drive();
    logic [3:0] d;
    logic [7:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 8'(cnt + off[k]);
      d[k] = v[k];
      if (stuck_en[k]) d[k] = stuck_val[k];
      d[k] = d[k] ^ flip[k];
    end
    {div_16, div_8, div_4, div_2} = d;
  endtask

  // Present sample cnt, let one edge sample it, then look at outputs.
  task automatic tick();
    drive();
    @(posedge clk_in);
    #1;
    cnt_s = cnt;
    cnt   = cnt + 1;
    flip  = '0;
  endtask

  task automatic do_reset();
    cnt = 0;
    for (int k = 0; k < 4; k++) off[k] = 0;
    stuck_en = '0; stuck_val = '0; flip = '0;
    rst = 1'b1;
    drive();
    @(posedge clk_in);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_lock(output int at);
    at = -1;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (locked) begin
        at = cnt_s;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL reset_err: got %b want 0000", err); end
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", state); end
    n_cmp++; if ({locked, fail, phase_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {locked, fail, phase_err}); end
  endtask

  task automatic test_lock();
    int at;
    int bad;
    do_reset();
    wait_lock(at);
    n_cmp++; if (at !== 40) begin n_bad++; $display("FAIL lock_edge: got %0d want 40", at); end
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL lock_err: got %b want 0000", err); end
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL lock_state: got %b want 01", state); end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!(locked === 1'b1 && fail === 1'b0 && err === 4'b0000 && state === 2'b01)) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL lock_hold: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_stuck_div8();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cnt_s % 8 == 4) break;
    end
    stuck_en[2] = 1'b1;
    stuck_val[2] = 1'b1;
    repeat (4) tick();
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL stuck8_early: got %b want 0000", err); end
`ifndef CLK_DIV_CHK_PHASE_EN
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL stuck8_still_locked: got %b want 1", locked); end
`endif
    tick();
    n_cmp++; if (err !== 4'b0100) begin n_bad++; $display("FAIL stuck8_err: got %b want 0100", err); end
    n_cmp++; if ({locked, fail, state} !== 4'b0110) begin n_bad++; $display("FAIL stuck8_status: got %b want 0110", {locked, fail, state}); end
  endtask

  task automatic test_late_div4();
    int at;
    do_reset();
    wait_lock(at);
    n_cmp++; if (at !== 40) begin n_bad++; $display("FAIL late4_lock: got %0d want 40", at); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cnt_s % 2 == 0) break;
    end
    off[1] = -1;
    repeat (2) tick();
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL late4_early: got %b want 0000", err); end
    tick();
    n_cmp++; if (err !== 4'b0010) begin n_bad++; $display("FAIL late4_err: got %b want 0010", err); end
    n_cmp++; if ({locked, fail, state} !== 4'b0110) begin n_bad++; $display("FAIL late4_status: got %b want 0110", {locked, fail, state}); end
  endtask

  task automatic test_rst_in_fail();
    int at;
    stuck_en[3] = 1'b1;
    stuck_val[3] = div_16;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (err === 4'b1010) break;
    end
    n_cmp++; if (err !== 4'b1010) begin n_bad++; $display("FAIL rst_pre_err: got %b want 1010", err); end
    do_reset();
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL rst_err: got %b want 0000", err); end
    n_cmp++; if ({locked, fail, state} !== 4'b0000) begin n_bad++; $display("FAIL rst_status: got %b want 0000", {locked, fail, state}); end
    wait_lock(at);
    n_cmp++; if (at !== 40) begin n_bad++; $display("FAIL rst_relock: got %0d want 40", at); end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 32; i++) begin
      tick();
      if (cnt_s % 16 == 1) break;
    end
    flip = 4'b0001;
    tick();
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL glitch_early: got %b want 0000", err); end
    flip = 4'b1000;
    tick();
    n_cmp++; if (err !== 4'b1001) begin n_bad++; $display("FAIL glitch_err: got %b want 1001", err); end
    n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL glitch_state: got %b want 10", state); end
  endtask

  task automatic test_phase();
    int at;
    int bad;
    do_reset();
    off[3] = 2;
`ifdef CLK_DIV_CHK_PHASE_EN
    at = -1;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (fail) begin
        at = cnt_s;
        break;
      end
    end
    n_cmp++; if (at !== 14) begin n_bad++; $display("FAIL phase_fail_edge: got %0d want 14", at); end
    n_cmp++; if (phase_err !== 1'b1) begin n_bad++; $display("FAIL phase_flag: got %b want 1", phase_err); end
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL phase_err_bits: got %b want 0000", err); end
`else
    wait_lock(at);
    n_cmp++; if (at !== 38) begin n_bad++; $display("FAIL phase_lock_edge: got %0d want 38", at); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!(locked === 1'b1 && phase_err === 1'b0 && err === 4'b0000)) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL phase_hold: got %0d bad cycles want 0", bad); end
`endif
  endtask

  initial begin
    for (int k = 0; k < 4; k++) off[k] = 0;
    stuck_en = '0; stuck_val = '0; flip = '0; cnt = 0; cnt_s = 0;
    test_reset();
    test_lock();
    test_stuck_div8();
    test_late_div4();
    test_rst_in_fail();
    test_glitch();
    test_phase();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
